ddr_a2m_cmd_arb: RTL and testbench

- Command scheduler at the front of the AXI-to-MBA bridge.
- Arbitrates the AXI write-address (AW) and read-address (AR) channels onto the single MBA command port, round-robin.
- Converts each accepted INCR burst into a byte count, then issues one or more MBA commands so that no command crosses a P_MAX_BYTES-aligned boundary.
- Holds one burst at a time; no switching between channels mid-burst.

---
 rtl/ddr_a2m_cmd_arb_pkg.sv | 38 +++
 rtl/ddr_a2m_chunk_calc.sv | 32 +++
 rtl/ddr_a2m_cmd_arb.sv | 180 ++++++++++++++++++
 tb/tb_ddr_a2m_cmd_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_a2m_cmd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_a2m_cmd_arb_pkg
// Brief    : Shared constants, state encoding and AXI burst-size helper for
//            the AXI-to-MBA command scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package ddr_a2m_cmd_arb_pkg;

    localparam int C_BYTES_W       = 13;
    localparam int C_MAX_BYTES_DEF = 256;

    localparam logic [2:0] C_SIZE_1B  = 3'd0;
    localparam logic [2:0] C_SIZE_2B  = 3'd1;
    localparam logic [2:0] C_SIZE_4B  = 3'd2;
    localparam logic [2:0] C_SIZE_8B  = 3'd3;
    localparam logic [2:0] C_SIZE_16B = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Unsupported sizes report zero bytes; the caller treats zero as an error.
    function automatic logic [C_BYTES_W-1:0] axi_total_bytes(
        input logic [7:0] len,
        input logic [2:0] size
    );
        logic [C_BYTES_W-1:0] beats;
        beats = {5'd0, len} + 13'd1;
        if (size <= C_SIZE_16B)
            return beats << size;
        else
            return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_a2m_chunk_calc.sv
`default_nettype none
// ============================================================================
// Module   : ddr_a2m_chunk_calc
// Brief    : Combinational chunk sizer: bytes to the next P_MAX_BYTES
//            boundary, clipped to the remaining burst length.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_a2m_chunk_calc
    import ddr_a2m_cmd_arb_pkg::*;
#(
    parameter int P_ADDR_W    = 32,
    parameter int P_MAX_BYTES = C_MAX_BYTES_DEF
) (
    input  logic [P_ADDR_W-1:0]  addr,
    input  logic [C_BYTES_W-1:0] rem,
    output logic [C_BYTES_W-1:0] bytes,
    output logic                 last
);

    localparam int                   C_OFF_W = $clog2(P_MAX_BYTES);
    localparam logic [C_BYTES_W-1:0] C_MAX   = C_BYTES_W'(P_MAX_BYTES);

    logic [C_BYTES_W-1:0] w_room;

    // Room is never zero, so a burst ending on a boundary never yields an
    // empty trailing chunk.
    assign w_room = C_MAX - C_BYTES_W'(addr[C_OFF_W-1:0]);
    assign bytes  = (rem < w_room) ? rem : w_room;
    assign last   = (bytes == rem);

endmodule
`default_nettype wire

// File: rtl/ddr_a2m_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : ddr_a2m_cmd_arb
// Brief    : AW/AR round-robin arbiter that splits INCR bursts into MBA
//            commands which never cross a P_MAX_BYTES boundary.
//            Define DDR_A2M_CMD_ARB_RDPRIO_EN for fixed read-over-write
//            priority on ties.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_a2m_cmd_arb
    import ddr_a2m_cmd_arb_pkg::*;
#(
    parameter int P_ADDR_W    = 32,
    parameter int P_ID_W      = 4,
    parameter int P_MAX_BYTES = C_MAX_BYTES_DEF
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,

    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [P_ADDR_W-1:0]  AWADDR,
    input  logic [7:0]           AWLEN,
    input  logic [2:0]           AWSIZE,
    input  logic [P_ID_W-1:0]    AWID,

    input  logic                 ARVALID,
    output logic                 ARREADY,
    input  logic [P_ADDR_W-1:0]  ARADDR,
    input  logic [7:0]           ARLEN,
    input  logic [2:0]           ARSIZE,
    input  logic [P_ID_W-1:0]    ARID,

    output logic                 MCMD_VALID,
    input  logic                 MCMD_READY,
    output logic                 MCMD_WR,
    output logic [P_ADDR_W-1:0]  MCMD_ADDR,
    output logic [C_BYTES_W-1:0] MCMD_BYTES,
    output logic [P_ID_W-1:0]    MCMD_ID,
    output logic                 MCMD_LAST,
    output logic                 ERR_PULSE
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_wr;
    logic                  r_wr;
    logic [P_ADDR_W-1:0]   r_addr;
    logic [C_BYTES_W-1:0]  r_rem;
    logic [C_BYTES_W-1:0]  r_bytes;
    logic                  r_last;
    logic [P_ID_W-1:0]     r_id;
    logic                  r_err;

    logic                  w_idle;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_hs;
    logic                  w_hs_ok;
    logic                  w_hs_err;
    logic                  w_advance;

    logic [C_BYTES_W-1:0]  w_aw_total;
    logic [C_BYTES_W-1:0]  w_ar_total;
    logic [C_BYTES_W-1:0]  w_cap_total;
    logic [P_ADDR_W-1:0]   w_cap_raw;
    logic [2:0]            w_cap_size;
    logic [P_ADDR_W-1:0]   w_cap_addr;
    logic [P_ID_W-1:0]     w_cap_id;

    logic [P_ADDR_W-1:0]   w_calc_addr;
    logic [C_BYTES_W-1:0]  w_calc_rem;
    logic [C_BYTES_W-1:0]  w_calc_bytes;
    logic                  w_calc_last;

    assign w_aw_total = axi_total_bytes(AWLEN, AWSIZE);
    assign w_ar_total = axi_total_bytes(ARLEN, ARSIZE);

    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (AWVALID && ARVALID) begin
`ifdef DDR_A2M_CMD_ARB_RDPRIO_EN
            w_grant_rd = 1'b1;
`else
            w_grant_rd = r_last_wr;
            w_grant_wr = !r_last_wr;
`endif
        end else begin
            w_grant_wr = AWVALID;
            w_grant_rd = ARVALID;
        end
    end

    assign w_idle   = (r_state == ST_IDLE);
    assign AWREADY  = w_idle && w_grant_wr;
    assign ARREADY  = w_idle && w_grant_rd;
    assign w_hs     = AWREADY || ARREADY;

    assign w_cap_raw   = w_grant_wr ? AWADDR     : ARADDR;
    assign w_cap_size  = w_grant_wr ? AWSIZE     : ARSIZE;
    assign w_cap_total = w_grant_wr ? w_aw_total : w_ar_total;
    assign w_cap_id    = w_grant_wr ? AWID       : ARID;
    assign w_cap_addr  = w_cap_raw &
                         ~((P_ADDR_W'(1) << w_cap_size) - P_ADDR_W'(1));

    assign w_hs_err  = w_hs && (w_cap_total == '0);
    assign w_hs_ok   = w_hs && (w_cap_total != '0);
    assign w_advance = !w_idle && MCMD_READY && !r_last;

    // One sizer serves both the capture edge and every chunk advance.
    assign w_calc_addr = w_idle ? w_cap_addr  : (r_addr + P_ADDR_W'(r_bytes));
    assign w_calc_rem  = w_idle ? w_cap_total : (r_rem - r_bytes);

    ddr_a2m_chunk_calc #(
        .P_ADDR_W    (P_ADDR_W),
        .P_MAX_BYTES (P_MAX_BYTES)
    ) u_chunk_calc (
        .addr  (w_calc_addr),
        .rem   (w_calc_rem),
        .bytes (w_calc_bytes),
        .last  (w_calc_last)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_hs_ok) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (MCMD_READY && r_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_last_wr <= 1'b1;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_rem     <= '0;
            r_bytes   <= '0;
            r_last    <= 1'b0;
            r_id      <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_hs_err;
            if (w_hs)
                r_last_wr <= w_grant_wr;
            if (w_hs_ok) begin
                r_wr    <= w_grant_wr;
                r_id    <= w_cap_id;
                r_addr  <= w_cap_addr;
                r_rem   <= w_cap_total;
                r_bytes <= w_calc_bytes;
                r_last  <= w_calc_last;
            end else if (w_advance) begin
                r_addr  <= w_calc_addr;
                r_rem   <= w_calc_rem;
                r_bytes <= w_calc_bytes;
                r_last  <= w_calc_last;
            end
        end
    end

    assign MCMD_VALID = (r_state == ST_ISSUE);
    assign MCMD_WR    = r_wr;
    assign MCMD_ADDR  = r_addr;
    assign MCMD_BYTES = r_bytes;
    assign MCMD_ID    = r_id;
    assign MCMD_LAST  = r_last;
    assign ERR_PULSE  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_a2m_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_a2m_cmd_arb
// Brief    : Directed self-checking bench for ddr_a2m_cmd_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_a2m_cmd_arb;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        AWVALID, ARVALID;
    logic        AWREADY, ARREADY;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [3:0]  AWID, ARID;
    logic        MCMD_VALID, MCMD_READY, MCMD_WR, MCMD_LAST, ERR_PULSE;
    logic [31:0] MCMD_ADDR;
    logic [12:0] MCMD_BYTES;
    logic [3:0]  MCMD_ID;

    int   n_vec = 0;
    int   n_err = 0;
    int   nr;
    int   nw;
    logic exp_rd;

    always #5 ACLK = ~ACLK;

    ddr_a2m_cmd_arb dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .AWADDR     (AWADDR),
        .AWLEN      (AWLEN),
        .AWSIZE     (AWSIZE),
        .AWID       (AWID),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .ARADDR     (ARADDR),
        .ARLEN      (ARLEN),
        .ARSIZE     (ARSIZE),
        .ARID       (ARID),
        .MCMD_VALID (MCMD_VALID),
        .MCMD_READY (MCMD_READY),
        .MCMD_WR    (MCMD_WR),
        .MCMD_ADDR  (MCMD_ADDR),
        .MCMD_BYTES (MCMD_BYTES),
        .MCMD_ID    (MCMD_ID),
        .MCMD_LAST  (MCMD_LAST),
        .ERR_PULSE  (ERR_PULSE)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN = 1'b0; AWVALID = 1'b0; ARVALID = 1'b0; MCMD_READY = 1'b0;
        AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWID = '0;
        ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARID = '0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_valid", MCMD_VALID, 0);
        chk("rst_err",   ERR_PULSE, 0);
        chk("rst_bytes", MCMD_BYTES, 0);
        chk("rst_awrdy", AWREADY, 0);
        ARESETN = 1'b1;
        cyc();

        // Single 16-byte read
        MCMD_READY = 1'b1;
        ARADDR = 32'h100; ARLEN = 8'd3; ARSIZE = 3'd2; ARID = 4'h5; ARVALID = 1'b1;
        #1;
        chk("t1_arready", ARREADY, 1);
        chk("t1_awready", AWREADY, 0);
        chk("t1_valid_pre", MCMD_VALID, 0);
        cyc(); ARVALID = 1'b0;
        chk("t1_valid", MCMD_VALID, 1);
        chk("t1_wr",    MCMD_WR, 0);
        chk("t1_addr",  MCMD_ADDR, 32'h100);
        chk("t1_bytes", MCMD_BYTES, 16);
        chk("t1_last",  MCMD_LAST, 1);
        chk("t1_id",    MCMD_ID, 4'h5);
        cyc();
        chk("t1_done", MCMD_VALID, 0);

        // 256-byte write straddling 0x100
        AWADDR = 32'h0F0; AWLEN = 8'd15; AWSIZE = 3'd4; AWID = 4'h9; AWVALID = 1'b1;
        #1;
        chk("t2_awready", AWREADY, 1);
        cyc(); AWVALID = 1'b0;
        chk("t2_c0_wr",    MCMD_WR, 1);
        chk("t2_c0_addr",  MCMD_ADDR, 32'h0F0);
        chk("t2_c0_bytes", MCMD_BYTES, 16);
        chk("t2_c0_last",  MCMD_LAST, 0);
        cyc();
        chk("t2_c1_addr",  MCMD_ADDR, 32'h100);
        chk("t2_c1_bytes", MCMD_BYTES, 240);
        chk("t2_c1_last",  MCMD_LAST, 1);
        chk("t2_c1_id",    MCMD_ID, 4'h9);
        cyc();
        chk("t2_done", MCMD_VALID, 0);

        // Unaligned start, burst ends exactly on a boundary
        ARADDR = 32'h87; ARLEN = 8'd7; ARSIZE = 3'd4; ARID = 4'h2; ARVALID = 1'b1;
        #1;
        chk("tb_arready", ARREADY, 1);
        cyc(); ARVALID = 1'b0;
        chk("tb_addr",  MCMD_ADDR, 32'h80);
        chk("tb_bytes", MCMD_BYTES, 128);
        chk("tb_last",  MCMD_LAST, 1);
        cyc();
        chk("tb_done", MCMD_VALID, 0);

        // Tie arbitration from reset, four single-byte bursts per channel
        ARESETN = 1'b0; #2; ARESETN = 1'b1;
        cyc();
        nr = 0; nw = 0;
        ARADDR = 32'h10; ARLEN = 8'd0; ARSIZE = 3'd0; ARID = 4'hA; ARVALID = 1'b1;
        AWADDR = 32'h20; AWLEN = 8'd0; AWSIZE = 3'd0; AWID = 4'hB; AWVALID = 1'b1;
        for (int i = 0; i < 8; i++) begin
`ifdef DDR_A2M_CMD_ARB_RDPRIO_EN
            exp_rd = (i < 4);
`else
            exp_rd = ((i % 2) == 0);
`endif
            #1;
            chk("t3_arready", ARREADY, exp_rd);
            chk("t3_awready", AWREADY, !exp_rd);
            cyc();
            if (exp_rd) begin
                nr++;
                if (nr == 4) ARVALID = 1'b0;
            end else begin
                nw++;
                if (nw == 4) AWVALID = 1'b0;
            end
            chk("t3_wr", MCMD_WR, !exp_rd);
            chk("t3_id", MCMD_ID, exp_rd ? 4'hA : 4'hB);
            cyc();
        end

        // Unsupported size: error pulse, no command, then a normal write
        ARADDR = 32'h200; ARLEN = 8'd0; ARSIZE = 3'd5; ARVALID = 1'b1;
        #1;
        chk("t4_arready", ARREADY, 1);
        cyc(); ARVALID = 1'b0;
        chk("t4_err",   ERR_PULSE, 1);
        chk("t4_valid", MCMD_VALID, 0);
        cyc();
        chk("t4_err_off",   ERR_PULSE, 0);
        chk("t4_valid_off", MCMD_VALID, 0);
        AWADDR = 32'h40; AWLEN = 8'd0; AWSIZE = 3'd3; AWID = 4'h3; AWVALID = 1'b1;
        #1;
        chk("t4_awready", AWREADY, 1);
        cyc(); AWVALID = 1'b0;
        chk("t4_w_valid", MCMD_VALID, 1);
        chk("t4_w_addr",  MCMD_ADDR, 32'h40);
        chk("t4_w_bytes", MCMD_BYTES, 8);
        chk("t4_w_last",  MCMD_LAST, 1);
        cyc();
        chk("t4_w_done", MCMD_VALID, 0);

        // 4096-byte burst with stalls between chunks
        MCMD_READY = 1'b0;
        AWADDR = 32'h0; AWLEN = 8'd255; AWSIZE = 3'd4; AWID = 4'h6; AWVALID = 1'b1;
        #1;
        chk("t5_awready", AWREADY, 1);
        cyc(); AWVALID = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("t5_addr",  MCMD_ADDR, k * 256);
            chk("t5_bytes", MCMD_BYTES, 256);
            chk("t5_last",  MCMD_LAST, (k == 15) ? 1 : 0);
            MCMD_READY = 1'b0;
            cyc();
            chk("t5_stall_valid", MCMD_VALID, 1);
            chk("t5_stall_addr",  MCMD_ADDR, k * 256);
            MCMD_READY = 1'b1;
            cyc();
        end
        chk("t5_done", MCMD_VALID, 0);

        // Reset in the middle of a burst
        AWVALID = 1'b1;
        #1;
        chk("t6_awready", AWREADY, 1);
        cyc(); AWVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t6_addr", MCMD_ADDR, k * 256);
            cyc();
        end
        chk("t6_c5_addr", MCMD_ADDR, 32'h500);
        chk("t6_c5_valid", MCMD_VALID, 1);
        ARESETN = 1'b0;
        #1;
        chk("t6_rst_valid", MCMD_VALID, 0);
        chk("t6_rst_bytes", MCMD_BYTES, 0);
        chk("t6_rst_addr",  MCMD_ADDR, 0);
        cyc();
        ARESETN = 1'b1;
        AWADDR = 32'h300; AWLEN = 8'd0; AWSIZE = 3'd2; AWID = 4'h7; AWVALID = 1'b1;
        #1;
        chk("t6_awready", AWREADY, 1);
        cyc(); AWVALID = 1'b0;
        chk("t6_n_valid", MCMD_VALID, 1);
        chk("t6_n_addr",  MCMD_ADDR, 32'h300);
        chk("t6_n_bytes", MCMD_BYTES, 4);
        chk("t6_n_last",  MCMD_LAST, 1);
        cyc();
        chk("t6_n_done", MCMD_VALID, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
